scr1_imem_responder: RTL and testbench

//  Synthesizable instruction-memory responder for the SCR1 native IMEM interface (core side = initiator).

---
 rtl/scr1_memif_pkg.sv | 24 ++
 rtl/scr1_imem_resp_dly.sv | 32 +++
 rtl/scr1_imem_responder.sv | 94 +++++++++
 tb/tb_scr1_imem_responder.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_memif_pkg.sv
// Shared SCR1 native memory-interface types, plus the response record carried
// through the instruction-memory responder's latency line.
package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  localparam int unsigned SCR1_IMEM_RESP_LAT_MAX = 8;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] data;
  } type_scr1_imem_rsp_s;

endpackage

// File: rtl/scr1_imem_resp_dly.sv
// Fixed-latency shift line for fetch responses; only the valid flags are reset,
// payload simply follows its valid bit down the line.
module scr1_imem_resp_dly
  import scr1_memif_pkg::*;
#(
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  type_scr1_imem_rsp_s push,
  output type_scr1_imem_rsp_s pop
);

  for (genvar g = 0; g < RESP_LATENCY; g++) begin : g_stage
    type_scr1_imem_rsp_s stage_q;

    if (g == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q.vld <= 1'b0;
        else        stage_q     <= push;
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q.vld <= 1'b0;
        else        stage_q     <= g_stage[g-1].stage_q;
      end
    end
  end

  assign pop = g_stage[RESP_LATENCY-1].stage_q;

endmodule

// File: rtl/scr1_imem_responder.sv
// Instruction-memory responder for the SCR1 native IMEM port: preloadable word
// array, read and error-checked at accept, answered in order after a fixed latency.
module scr1_imem_responder
  import scr1_memif_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned RESP_LATENCY = 1,
  parameter int unsigned OUTSTANDING  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         imem_req,
  input  logic                         imem_cmd,
  input  logic [31:0]                  imem_addr,
  output logic                         imem_req_ack,
  output logic [31:0]                  imem_rdata,
  output logic [1:0]                   imem_resp,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_widx,
  input  logic [31:0]                  ld_data,
  output logic [15:0]                  err_cnt
);

  localparam int unsigned AW   = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

  logic [31:0]         mem [MEM_WORDS];
  logic [31:0]         offset;
  logic                addr_err;
  logic                accept;
  logic                resp_fire;
  logic [3:0]          pend_cnt;
  type_scr1_imem_rsp_s push;
  type_scr1_imem_rsp_s pop;

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_widx] <= ld_data;
  end

  // Unsigned offset wraps for addresses below BASE_ADDR, so one compare covers both bounds.
  always_comb begin
    offset    = imem_addr - BASE_ADDR;
    addr_err  = (imem_addr[1:0] != 2'b00) | ({1'b0, offset} >= SPAN)
              | (imem_cmd != SCR1_MEM_CMD_RD);
    push      = '0;
    push.vld  = accept;
    push.err  = addr_err;
    push.data = addr_err ? '0 : mem[offset[AW+1:2]];
  end

  assign resp_fire    = pop.vld;
  assign imem_req_ack = rst_n & ~ld_en & ((pend_cnt < 4'(OUTSTANDING)) | resp_fire);
  assign accept       = imem_req & imem_req_ack;

  scr1_imem_resp_dly #(
    .RESP_LATENCY (RESP_LATENCY)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
    end else begin
      case ({accept, resp_fire})
        2'b10:   pend_cnt <= pend_cnt + 4'd1;
        2'b01:   pend_cnt <= pend_cnt - 4'd1;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (resp_fire && pop.err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  always_comb begin
    imem_resp  = SCR1_MEM_RESP_NOTRDY;
    imem_rdata = '0;
    if (pop.vld) begin
      imem_resp = pop.err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      if (!pop.err) imem_rdata = pop.data;
    end
  end

endmodule

// File: tb/tb_scr1_imem_responder.sv
// Bench for scr1_imem_responder: three configurations driven side by side and
// checked against a queue-of-due-responses reference model.
module tb_scr1_imem_responder;
  import scr1_memif_pkg::*;

  localparam int          NI     = 3;
  localparam int unsigned MW     = 1024;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_1000;
  localparam logic [31:0] BASE_C = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req     [NI];
  logic        cmd     [NI];
  logic [31:0] addr    [NI];
  logic        ld_en   [NI];
  logic [9:0]  ld_widx [NI];
  logic [31:0] ld_data [NI];
  logic        ack     [NI];
  logic [31:0] rdata   [NI];
  logic [1:0]  resp    [NI];
  logic [15:0] errc    [NI];

  always #5 clk = ~clk;

  scr1_imem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE_A), .RESP_LATENCY(1), .OUTSTANDING(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .imem_req(req[0]), .imem_cmd(cmd[0]), .imem_addr(addr[0]),
    .imem_req_ack(ack[0]), .imem_rdata(rdata[0]), .imem_resp(resp[0]),
    .ld_en(ld_en[0]), .ld_widx(ld_widx[0]), .ld_data(ld_data[0]), .err_cnt(errc[0]));

  scr1_imem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE_B), .RESP_LATENCY(3), .OUTSTANDING(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .imem_req(req[1]), .imem_cmd(cmd[1]), .imem_addr(addr[1]),
    .imem_req_ack(ack[1]), .imem_rdata(rdata[1]), .imem_resp(resp[1]),
    .ld_en(ld_en[1]), .ld_widx(ld_widx[1]), .ld_data(ld_data[1]), .err_cnt(errc[1]));

  scr1_imem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE_C), .RESP_LATENCY(3), .OUTSTANDING(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .imem_req(req[2]), .imem_cmd(cmd[2]), .imem_addr(addr[2]),
    .imem_req_ack(ack[2]), .imem_rdata(rdata[2]), .imem_resp(resp[2]),
    .ld_en(ld_en[2]), .ld_widx(ld_widx[2]), .ld_data(ld_data[2]), .err_cnt(errc[2]));

  // Reference model: a list of promised responses, each tagged with the cycle it is due.
  typedef struct {
    longint      due;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        expq    [NI][$];
  logic [32:0] fq      [NI][$];
  logic [31:0] mmem    [NI][MW];
  int unsigned m_errc  [NI];
  longint      cyc;
  bit          e_due   [NI];
  bit          acc     [NI];
  logic        e_ack   [NI];
  logic [1:0]  e_resp  [NI];
  logic [31:0] e_rdata [NI];
  logic [15:0] e_errc  [NI];
  int          vectors;
  int          fails;

  function automatic int unsigned lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int unsigned outs_of(int k);
    return (k == 1) ? 1 : 2;
  endfunction

  function automatic longint base_of(int k);
    case (k)
      0:       return longint'(BASE_A);
      1:       return longint'(BASE_B);
      default: return longint'(BASE_C);
    endcase
  endfunction

  function automatic bit is_err(int k, logic c, logic [31:0] a);
    longint la = longint'(a);
    return (la % 4 != 0) || (la < base_of(k)) || (la >= base_of(k) + 4 * MW) || (c != 1'b0);
  endfunction

  function automatic void model_eval();
    for (int k = 0; k < NI; k++) begin
      e_due[k] = 1'b0;
      if (rst_n && expq[k].size() > 0)
        if (expq[k][0].due == cyc) e_due[k] = 1'b1;
      e_ack[k]   = rst_n && !ld_en[k] && ((expq[k].size() < int'(outs_of(k))) || e_due[k]);
      e_resp[k]  = 2'b00;
      e_rdata[k] = 32'h0;
      if (e_due[k]) begin
        e_resp[k] = expq[k][0].err ? 2'b10 : 2'b01;
        if (!expq[k][0].err) e_rdata[k] = expq[k][0].data;
      end
      e_errc[k] = rst_n ? 16'(m_errc[k]) : 16'h0;
    end
  endfunction

  function automatic void model_commit();
    exp_t ent;
    model_eval();
    for (int k = 0; k < NI; k++) begin
      acc[k] = 1'b0;
      if (!rst_n) begin
        expq[k].delete();
        m_errc[k] = 0;
      end else begin
        if (e_due[k]) begin
          if (expq[k][0].err && m_errc[k] < 65535) m_errc[k]++;
          void'(expq[k].pop_front());
        end
        if (req[k] && e_ack[k]) begin
          acc[k]   = 1'b1;
          ent.due  = cyc + longint'(lat_of(k));
          ent.err  = is_err(k, cmd[k], addr[k]);
          ent.data = ent.err ? 32'h0 : mmem[k][int'((longint'(addr[k]) - base_of(k)) / 4)];
          expq[k].push_back(ent);
        end
      end
      if (ld_en[k]) mmem[k][ld_widx[k]] = ld_data[k];
    end
    cyc++;
  endfunction

  task automatic step();
    @(posedge clk);
    model_commit();
    for (int k = 0; k < NI; k++)
      if (acc[k] && fq[k].size() > 0) void'(fq[k].pop_front());
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; cmd[k] = 1'b0; addr[k] = 32'h0;
      ld_en[k] = 1'b0; ld_widx[k] = 10'h0; ld_data[k] = 32'h0;
    end
  endtask

  task automatic drive_from_q();
    logic [32:0] f;
    for (int k = 0; k < NI; k++) begin
      if (fq[k].size() > 0) begin
        f = fq[k][0];
        req[k] = 1'b1; cmd[k] = f[32]; addr[k] = f[31:0];
      end else begin
        req[k] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    for (int k = 0; k < NI; k++) req[k] = 1'b1;
    step();
    sample();
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (ack[k] !== 1'b0 || resp[k] !== 2'b00 || rdata[k] !== 32'h0 || errc[k] !== 16'h0) begin
        fails++;
        $display("FAIL reset dut%0d ack/resp/rdata/errc got %0b/%0d/%h/%0d want 0/0/0/0",
                 k, ack[k], resp[k], rdata[k], errc[k]);
      end
    end
    step();
    rst_n = 1'b1;
    idle_all();
  endtask

  task automatic test_preload();
    for (int w = 0; w < int'(MW); w++) begin
      for (int k = 0; k < NI; k++) begin
        ld_en[k] = 1'b1; ld_widx[k] = 10'(w); ld_data[k] = $urandom;
        req[k] = 1'b1; addr[k] = 32'(base_of(k)) + 32'(4 * w);
      end
      if (w == 0) ld_data[0] = 32'h0000_0013;
      if (w == 1) ld_data[0] = 32'h0020_A233;
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (ack[k] !== 1'b0) begin
          fails++;
          $display("FAIL preload_ack dut%0d word %0d got %0b want 0", k, w, ack[k]);
        end
      end
      step();
    end
    idle_all();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  want_resp [4] = '{2'b00, 2'b01, 2'b01, 2'b00};
    logic [31:0] want_rd   [4] = '{32'h0, 32'h0000_0013, 32'h0020_A233, 32'h0};
    fq[0].push_back({1'b0, 32'h0});
    fq[0].push_back({1'b0, 32'h4});
    for (int i = 0; i < 4; i++) begin
      drive_from_q();
      sample();
      vectors++;
      if (resp[0] !== want_resp[i] || rdata[0] !== want_rd[i] || (i < 2 && ack[0] !== 1'b1)) begin
        fails++;
        $display("FAIL b2b cycle %0d ack/resp/rdata got %0b/%0d/%h want %0b/%0d/%h",
                 i, ack[0], resp[0], rdata[0], (i < 2), want_resp[i], want_rd[i]);
      end
      vectors++;
      if (ack[0] !== e_ack[0] || resp[0] !== e_resp[0] || rdata[0] !== e_rdata[0]) begin
        fails++;
        $display("FAIL b2b_model cycle %0d ack/resp/rdata got %0b/%0d/%h want %0b/%0d/%h",
                 i, ack[0], resp[0], rdata[0], e_ack[0], e_resp[0], e_rdata[0]);
      end
      step();
    end
  endtask

  task automatic test_throttle();
    longint acc_c [$];
    longint rsp_c [$];
    for (int j = 0; j < 3; j++) fq[1].push_back({1'b0, BASE_B + 32'(4 * j)});
    for (int i = 0; i < 16; i++) begin
      drive_from_q();
      sample();
      vectors++;
      if (ack[1] !== e_ack[1] || resp[1] !== e_resp[1] || rdata[1] !== e_rdata[1]) begin
        fails++;
        $display("FAIL throttle cyc %0d ack/resp/rdata got %0b/%0d/%h want %0b/%0d/%h",
                 cyc, ack[1], resp[1], rdata[1], e_ack[1], e_resp[1], e_rdata[1]);
      end
      if (req[1] && ack[1]) acc_c.push_back(cyc);
      if (resp[1] !== 2'b00) rsp_c.push_back(cyc);
      step();
    end
    vectors++;
    if (acc_c.size() != 3 || rsp_c.size() != 3) begin
      fails++;
      $display("FAIL throttle_count accepts/responses got %0d/%0d want 3/3", acc_c.size(), rsp_c.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (rsp_c[j] != acc_c[j] + 3 || (j > 0 && acc_c[j] - acc_c[j-1] != 3)) begin
          fails++;
          $display("FAIL throttle_timing fetch %0d accept %0d response %0d want response accept+3, accept gap 3",
                   j, acc_c[j], rsp_c[j]);
        end
      end
    end
  endtask

  task automatic test_errors();
    fq[0].push_back({1'b0, 32'h0000_0002});
    fq[0].push_back({1'b0, BASE_A + 32'(4 * MW)});
    fq[1].push_back({1'b0, BASE_B - 32'd4});
    fq[2].push_back({1'b1, BASE_C});
    for (int i = 0; i < 8; i++) begin
      drive_from_q();
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (ack[k] !== e_ack[k] || resp[k] !== e_resp[k] || rdata[k] !== e_rdata[k] || errc[k] !== e_errc[k]) begin
          fails++;
          $display("FAIL errors dut%0d cyc %0d ack/resp/rdata/errc got %0b/%0d/%h/%0d want %0b/%0d/%h/%0d",
                   k, cyc, ack[k], resp[k], rdata[k], errc[k], e_ack[k], e_resp[k], e_rdata[k], e_errc[k]);
        end
      end
      step();
    end
    vectors++;
    if (errc[0] !== 16'd2 || errc[1] !== 16'd1 || errc[2] !== 16'd1) begin
      fails++;
      $display("FAIL err_cnt got %0d/%0d/%0d want 2/1/1", errc[0], errc[1], errc[2]);
    end
  endtask

  task automatic test_preload_race();
    logic [31:0] old0 = mmem[0][2];
    logic [31:0] old2 = mmem[2][2];
    logic [31:0] got2 = 32'h0;
    fq[0].push_back({1'b0, 32'h8});
    fq[2].push_back({1'b0, 32'h8});
    for (int i = 0; i < 6; i++) begin
      drive_from_q();
      if (i == 1) begin
        req[0] = 1'b1; addr[0] = 32'hC;
        req[2] = 1'b1; addr[2] = 32'hC;
        for (int k = 0; k < NI; k += 2) begin
          ld_en[k] = 1'b1; ld_widx[k] = 10'd2; ld_data[k] = ~mmem[k][2];
        end
      end
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (ack[k] !== e_ack[k] || resp[k] !== e_resp[k] || rdata[k] !== e_rdata[k]) begin
          fails++;
          $display("FAIL race dut%0d cyc %0d ack/resp/rdata got %0b/%0d/%h want %0b/%0d/%h",
                   k, cyc, ack[k], resp[k], rdata[k], e_ack[k], e_resp[k], e_rdata[k]);
        end
      end
      if (i == 1) begin
        vectors++;
        if (ack[0] !== 1'b0 || ack[2] !== 1'b0 || resp[0] !== 2'b01 || rdata[0] !== old0) begin
          fails++;
          $display("FAIL race_ld ack0/ack2/resp0/rdata0 got %0b/%0b/%0d/%h want 0/0/1/%h",
                   ack[0], ack[2], resp[0], rdata[0], old0);
        end
      end
      if (resp[2] === 2'b01) got2 = rdata[2];
      step();
      idle_all();
    end
    vectors++;
    if (got2 !== old2) begin
      fails++;
      $display("FAIL race_lat3 rdata got %h want %h", got2, old2);
    end
  endtask

  task automatic test_reset_inflight();
    fq[2].push_back({1'b0, 32'h0});
    fq[2].push_back({1'b0, 32'h4});
    for (int i = 0; i < 9; i++) begin
      drive_from_q();
      if (i == 2) begin
        rst_n = 1'b0;
        req[2] = 1'b1;
      end
      if (i == 3) fq[2].push_back({1'b0, 32'h4});
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (ack[k] !== e_ack[k] || resp[k] !== e_resp[k] || rdata[k] !== e_rdata[k] || errc[k] !== e_errc[k]) begin
          fails++;
          $display("FAIL rst_flight dut%0d cyc %0d ack/resp/rdata/errc got %0b/%0d/%h/%0d want %0b/%0d/%h/%0d",
                   k, cyc, ack[k], resp[k], rdata[k], errc[k], e_ack[k], e_resp[k], e_rdata[k], e_errc[k]);
        end
      end
      if (i >= 2 && i <= 5) begin
        vectors++;
        if (resp[2] !== 2'b00 || (i == 2 && ack[2] !== 1'b0)) begin
          fails++;
          $display("FAIL rst_stale cycle %0d ack/resp got %0b/%0d want %0b/0", i, ack[2], resp[2], (i != 2));
        end
      end
      step();
      rst_n = 1'b1;
    end
    idle_all();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2005; i++) begin
      for (int k = 0; k < NI; k++) begin
        if (i < 2000) begin
          req[k] = ($urandom_range(0, 3) != 0);
          cmd[k] = ($urandom_range(0, 15) == 0);
          case ($urandom_range(0, 9))
            0:       addr[k] = $urandom;
            1:       addr[k] = 32'(base_of(k)) + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
            2:       addr[k] = 32'(base_of(k)) + 32'(4 * MW) + 32'(4 * $urandom_range(0, 3));
            default: addr[k] = 32'(base_of(k)) + 32'(4 * $urandom_range(0, 1023));
          endcase
          ld_en[k]   = ($urandom_range(0, 7) == 0);
          ld_widx[k] = 10'($urandom_range(0, 1023));
          ld_data[k] = $urandom;
        end else begin
          req[k] = 1'b0; ld_en[k] = 1'b0;
        end
      end
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (ack[k] !== e_ack[k] || resp[k] !== e_resp[k] || rdata[k] !== e_rdata[k] || errc[k] !== e_errc[k]) begin
          fails++;
          $display("FAIL random dut%0d cyc %0d ack/resp/rdata/errc got %0b/%0d/%h/%0d want %0b/%0d/%h/%0d",
                   k, cyc, ack[k], resp[k], rdata[k], errc[k], e_ack[k], e_resp[k], e_rdata[k], e_errc[k]);
        end
      end
      step();
    end
    idle_all();
  endtask

  task automatic test_err_sat();
    int n_acc = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req[0] = 1'b1; addr[0] = 32'h0000_0002;
    for (int i = 0; i < 70000 && n_acc < 65538; i++) begin
      sample();
      vectors++;
      if (ack[0] !== e_ack[0] || resp[0] !== e_resp[0] || errc[0] !== e_errc[0]) begin
        fails++;
        $display("FAIL err_sat cyc %0d ack/resp/errc got %0b/%0d/%0d want %0b/%0d/%0d",
                 cyc, ack[0], resp[0], errc[0], e_ack[0], e_resp[0], e_errc[0]);
      end
      if (ack[0] === 1'b1) n_acc++;
      step();
    end
    req[0] = 1'b0;
    step();
    step();
    vectors++;
    if (n_acc != 65538 || errc[0] !== 16'hFFFF) begin
      fails++;
      $display("FAIL err_sat_final accepts/errc got %0d/%h want 65538/ffff", n_acc, errc[0]);
    end
  endtask

  initial begin
    vectors = 0;
    fails   = 0;
    test_reset();
    test_preload();
    test_back_to_back();
    test_throttle();
    test_errors();
    test_preload_race();
    test_reset_inflight();
    test_random();
    test_err_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
